hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Pipeline sequencer that sits beside the forwarding logic in the 5-stage MIPS core.
- Detects the hazards forwarding cannot resolve:
  - load-use;
  - HI/LO or MDU reuse while the multi-cycle multiply/divide unit (MDU) is busy;
  - taken-branch squash.
- Drives PC/IF_ID write-enables and bubble/flush controls.
- Tracks MDU occupancy with a latency counter and FSM, and keeps a stall-cycle performance counter.

Parameters:
- MDU_LAT, 4, MDU cycles from start to HI/LO valid; legal 1..15.
- CNT_W, 4, width of MDU countdown counter.
- STAT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_ID_Rs  in  5  source reg of instruction in ID
- IF_ID_Rt  in  5  second source reg of instruction in ID
- IF_ID_UsesRt  in  1  ID instruction reads Rt
- IF_ID_IsHiLo  in  1  ID instruction is MFHI/MFLO
- IF_ID_IsMdu  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- ID_Ex_MemRead  in  1  EX instruction is a load
- ID_Ex_Rt  in  5  load destination in EX
- Ex_MduStart  in  1  MDU op in EX this cycle (starts unit)
- Ex_BranchTaken  in  1  branch/jump resolved taken in EX
- Stat_Clr  in  1  synchronous clear of Stall_Cycles
- PC_Write  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  zero IF/ID contents
- ID_Ex_Flush  out  1  insert bubble into ID/EX
- Mdu_Busy  out  1  MDU result not yet valid
- Mdu_Done  out  1  one-cycle pulse when HI/LO becomes valid
- Stall_Cycles  out  STAT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0, async):
  - state=S_IDLE, counter=0, Stall_Cycles=0.
  - Outputs forced to PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_Ex_Flush=1, Mdu_Busy=0, Mdu_Done=0.
- Load-use hazard (combinational, same cycle):
  - Condition: load_hz = ID_Ex_MemRead & ID_Ex_Rt!=0 & (ID_Ex_Rt==IF_ID_Rs | (IF_ID_UsesRt & ID_Ex_Rt==IF_ID_Rt)).
  - Exactly one stall cycle results, because the load advances to MEM on the next edge.
- MDU hazard (combinational): mdu_hz = Mdu_Busy & (IF_ID_IsHiLo | IF_ID_IsMdu).
- Stall = (load_hz | mdu_hz) & ~Ex_BranchTaken. When Stall=1: PC_Write=0, IF_ID_Write=0, ID_Ex_Flush=1, IF_ID_Flush=0.
- Ex_BranchTaken=1 (priority over all stalls):
  - PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_Ex_Flush=1, for one cycle.
  - An MDU op already in flight continues; the counter is unaffected.
- Otherwise: PC_Write=1, IF_ID_Write=1, both flushes 0.
- FSM (registered):
  - S_IDLE: Mdu_Busy=0.
    - Ex_MduStart -> S_BUSY, counter=MDU_LAT-1.
    - If MDU_LAT=1, go to S_DONE instead.
  - S_BUSY: Mdu_Busy=1.
    - Counter decrements each cycle.
    - When counter==0 at an edge -> S_DONE.
  - S_DONE: Mdu_Busy=0, Mdu_Done=1 for exactly one cycle.
    - Ex_MduStart -> S_BUSY, counter reloads (back-to-back ops allowed).
    - Otherwise -> S_IDLE.
- Resulting timing: with start at edge N, Mdu_Busy is high for cycles N+1..N+MDU_LAT-1 and Mdu_Done pulses in cycle N+MDU_LAT.
- Ex_MduStart in S_BUSY is illegal, because ID stalls MDU ops while busy. Required response: assertion fires; the counter reloads to MDU_LAT-1.
- Stall_Cycles:
  - +1 on each edge where PC_Write=0 while out of reset.
  - Saturates at all-ones, no wrap.
  - Stat_Clr has priority and loads 0.
- Reset asserted mid-MDU-op: the counter and state clear immediately; no Mdu_Done pulse is produced.
- No false hazard on $0: load_hz requires ID_Ex_Rt!=0.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (S_IDLE, S_BUSY, S_DONE);
  - the MDU_LAT default;
  - the register-zero constant (5'd0).
- One natural sub-module: mdu_busy_tracker, which contains the FSM, counter, Mdu_Busy and Mdu_Done.
- The top-level module holds the hazard decode, output priority and Stall_Cycles.

Test Plan:
1. Load-use:
   - Stimulus: ID_Ex_MemRead=1, ID_Ex_Rt=8, IF_ID_Rs=8, for one cycle.
   - Response: PC_Write=0, IF_ID_Write=0, ID_Ex_Flush=1 in that cycle; Stall_Cycles 0->1.
   - With ID_Ex_Rt=0 instead: no stall.
2. Rt use:
   - Stimulus: IF_ID_Rt=8, ID_Ex_Rt=8, load in EX. Run once with IF_ID_UsesRt=0, then with IF_ID_UsesRt=1.
   - Response: no stall with UsesRt=0; stall with UsesRt=1.
3. MDU with MDU_LAT=4:
   - Stimulus: Ex_MduStart pulse, IF_ID_IsHiLo=1 held.
   - Response: stalled for 3 cycles; Mdu_Done in the 4th cycle, with PC_Write=1 in that cycle.
4. Branch priority:
   - Stimulus: Ex_BranchTaken=1 together with load_hz=1.
   - Response: PC_Write=1, IF_ID_Flush=1, ID_Ex_Flush=1; Stall_Cycles unchanged.
5. Saturation and clear:
   - Stimulus: STAT_W=4, force 20 stall cycles, then Stat_Clr.
   - Response: Stall_Cycles holds at 15; reads 0 on the cycle after Stat_Clr.
6. Reset mid-op:
   - Stimulus: rst_n=0 two cycles after Ex_MduStart, then release.
   - Response: Mdu_Busy=0 immediately; no Mdu_Done pulse follows; flush outputs =1 while in reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

    localparam int unsigned MDU_LAT_DEF = 4;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks occupancy of the multi-cycle multiply/divide unit.
// Produces a busy level and a one-cycle done pulse when HI/LO becomes valid.
module mdu_busy_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEF,
    parameter int unsigned CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Ex_MduStart,
    output logic Mdu_Busy,
    output logic Mdu_Done
);

    localparam logic [CNT_W-1:0] RELOAD      = CNT_W'(MDU_LAT - 1);
    localparam mdu_state_e       START_STATE = (MDU_LAT == 1) ? S_DONE : S_BUSY;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds busy cycles still to come, so DONE is entered on the edge where it reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (Ex_MduStart) begin
                    state_d = START_STATE;
                    cnt_d   = RELOAD;
                end
            end
            S_BUSY: begin
                if (Ex_MduStart) begin
                    cnt_d = RELOAD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (Ex_MduStart) begin
                    state_d = START_STATE;
                    cnt_d   = RELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign Mdu_Busy = (state_q == S_BUSY);
    assign Mdu_Done = (state_q == S_DONE);

    // ID must hold MDU ops while busy, so a start here means the stall logic failed.
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(Ex_MduStart && state_q == S_BUSY)
    );

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard detection and pipeline stall/flush sequencing for the 5-stage core.
// Combines load-use and MDU hazards, gives branch squash priority, counts stall cycles.
module hazard_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEF,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic              IF_ID_UsesRt,
    input  logic              IF_ID_IsHiLo,
    input  logic              IF_ID_IsMdu,
    input  logic              ID_Ex_MemRead,
    input  logic [4:0]        ID_Ex_Rt,
    input  logic              Ex_MduStart,
    input  logic              Ex_BranchTaken,
    input  logic              Stat_Clr,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_Ex_Flush,
    output logic              Mdu_Busy,
    output logic              Mdu_Done,
    output logic [STAT_W-1:0] Stall_Cycles
);

    logic load_hz;
    logic mdu_hz;
    logic stall;

    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    mdu_busy_tracker #(
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_busy_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .Ex_MduStart (Ex_MduStart),
        .Mdu_Busy    (Mdu_Busy),
        .Mdu_Done    (Mdu_Done)
    );

    assign load_hz = ID_Ex_MemRead && (ID_Ex_Rt != REG_ZERO) &&
                     ((ID_Ex_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_Ex_Rt == IF_ID_Rt)));
    assign mdu_hz  = Mdu_Busy && (IF_ID_IsHiLo || IF_ID_IsMdu);
    assign stall   = (load_hz || mdu_hz) && !Ex_BranchTaken;

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_Ex_Flush = 1'b0;
        if (!rst_n) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_Ex_Flush = 1'b1;
        end else if (Ex_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_Ex_Flush = 1'b1;
        end else if (stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_Ex_Flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stat_Clr) begin
            stall_cnt_d = '0;
        end else if (!PC_Write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cycles = stall_cnt_q;

endmodule
